// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants, width helpers and pointer type for the
// register-bank FIFO controller, its storage bank and the testbench.
//   DEPTH_DEFAULT : default number of storage entries
//   ptr_w()/cnt_w(): pointer / occupancy widths for a given depth
//   ptr_t         : pointer type sized for DEPTH_DEFAULT
package fifo_pkg;

  localparam int DEPTH_DEFAULT = 8;

  // A depth-1 FIFO would give $clog2 = 0, so pointers keep at least one bit.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Occupancy must represent 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  localparam int PTR_W = ptr_w(DEPTH_DEFAULT);
  localparam int CNT_W = cnt_w(DEPTH_DEFAULT);

  typedef logic [PTR_W-1:0] ptr_t;

endpackage

// File: rtl/fifo_ctrl_if.sv
// fifo_ctrl_if: push/pop handshake, storage-bank controls and status of the
// FIFO controller.
//   master : producer/consumer side (drives push, pop; observes the rest)
//   slave  : fifo_ctrl side (observes push, pop; drives the rest)
// Optional macro FIFO_CTRL_ERR_FLAGS_EN adds the sticky overflow/underflow
// flags.
interface fifo_ctrl_if import fifo_pkg::*; #(
  parameter int DEPTH = DEPTH_DEFAULT
) ();

  logic                      push;
  logic                      pop;
  logic [DEPTH-1:0]          wr_en;
  logic [ptr_w(DEPTH)-1:0]   rd_sel;
  logic                      push_ok;
  logic                      pop_ok;
  logic                      full;
  logic                      empty;
  logic                      almost_full;
  logic [cnt_w(DEPTH)-1:0]   count;
`ifdef FIFO_CTRL_ERR_FLAGS_EN
  logic                      overflow;
  logic                      underflow;
`endif

  modport master (
    output push, pop,
    input  wr_en, rd_sel, push_ok, pop_ok, full, empty, almost_full, count
`ifdef FIFO_CTRL_ERR_FLAGS_EN
    , input overflow, underflow
`endif
  );

  modport slave (
    input  push, pop,
    output wr_en, rd_sel, push_ok, pop_ok, full, empty, almost_full, count
`ifdef FIFO_CTRL_ERR_FLAGS_EN
    , output overflow, underflow
`endif
  );

endinterface

// File: rtl/fifo_ctrl_wrap_ctr.sv
// wrap_ctr: pointer counter that advances on inc and wraps from MAX to 0.
//   clk   : clock
//   rst_  : synchronous active-high reset (value -> 0)
//   inc   : advance enable
//   value : current pointer value
module wrap_ctr #(
  parameter int MAX = 7,
  parameter int W   = 3
) (
  input  logic         clk,
  input  logic         rst_,
  input  logic         inc,
  output logic [W-1:0] value
);

  logic [W-1:0] value_reg;
  logic [W-1:0] value_next;

  // Explicit compare against MAX so non-power-of-two depths wrap correctly.
  always_comb begin
    value_next = value_reg;
    if (inc) begin
      value_next = (value_reg == W'(MAX)) ? '0 : value_reg + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_) value_reg <= '0;
    else      value_reg <= value_next;
  end

  assign value = value_reg;

endmodule

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: sequencing and status for a register-bank FIFO of DEPTH entries.
//   clk  : clock, all state changes on rising edge
//   rst_ : synchronous active-high reset, priority over push/pop
//   bus  : fifo_ctrl_if.slave (push/pop in; wr_en, rd_sel, push_ok, pop_ok,
//          full, empty, almost_full, count out)
// Optional macro FIFO_CTRL_ERR_FLAGS_EN adds sticky overflow/underflow flags.
module fifo_ctrl import fifo_pkg::*; #(
  parameter int DEPTH    = DEPTH_DEFAULT,
  parameter int AF_LEVEL = DEPTH - 1
) (
  input  logic        clk,
  input  logic        rst_,
  fifo_ctrl_if.slave  bus
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;
  logic          full_int;
  logic          empty_int;
  logic          push_ok;
  logic          pop_ok;

  assign full_int  = (count_reg == CW'(DEPTH));
  assign empty_int = (count_reg == '0);

  // A pop frees a slot in the same cycle, so push is accepted at full when
  // paired with a pop. At empty the pop is refused, so the push stands alone.
  // Reset masks both so the storage bank is never written during reset.
  assign pop_ok  = ~rst_ & bus.pop & ~empty_int;
  assign push_ok = ~rst_ & bus.push & (~full_int | bus.pop);

  always_comb begin
    count_next = count_reg;
    case ({push_ok, pop_ok})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_) count_reg <= '0;
    else      count_reg <= count_next;
  end

  wrap_ctr #(.MAX(DEPTH - 1), .W(PW)) u_wr_ptr (
    .clk   (clk),
    .rst_  (rst_),
    .inc   (push_ok),
    .value (wr_ptr)
  );

  wrap_ctr #(.MAX(DEPTH - 1), .W(PW)) u_rd_ptr (
    .clk   (clk),
    .rst_  (rst_),
    .inc   (pop_ok),
    .value (rd_ptr)
  );

  // One-hot write enable: the entry at wr_ptr captures data on the same edge
  // that advances wr_ptr.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
    assign bus.wr_en[gi] = push_ok & (wr_ptr == PW'(gi));
  end

  assign bus.push_ok     = push_ok;
  assign bus.pop_ok      = pop_ok;
  assign bus.rd_sel      = rd_ptr;
  assign bus.count       = count_reg;
  assign bus.full        = full_int;
  assign bus.empty       = empty_int;
  assign bus.almost_full = (count_reg >= CW'(AF_LEVEL));

`ifdef FIFO_CTRL_ERR_FLAGS_EN
  logic overflow_reg;
  logic underflow_reg;

  // Sticky until reset; a push paired with a pop at full is legal.
  always_ff @(posedge clk) begin
    if (rst_) begin
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (bus.push & full_int & ~bus.pop) overflow_reg  <= 1'b1;
      if (bus.pop & empty_int)            underflow_reg <= 1'b1;
    end
  end

  assign bus.overflow  = overflow_reg;
  assign bus.underflow = underflow_reg;
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: drives a DEPTH=8 and a DEPTH=5 fifo_ctrl with identical
// push/pop/reset stimulus and compares every output each cycle against a
// reference built from running push/pop totals.
module tb_fifo_ctrl;
  import fifo_pkg::*;

  logic clk;
  logic rst_;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state per DUT: index 0 is DEPTH=8, index 1 is DEPTH=5.
  int dep[2]      = '{8, 5};
  int af_lvl[2]   = '{7, 4};
  int tot_push[2] = '{0, 0};
  int tot_pop[2]  = '{0, 0};
  bit of_flag[2]  = '{1'b0, 1'b0};
  bit uf_flag[2]  = '{1'b0, 1'b0};

  fifo_ctrl_if #(.DEPTH(8)) bus8 ();
  fifo_ctrl_if #(.DEPTH(5)) bus5 ();

  fifo_ctrl #(.DEPTH(8)) dut8 (.clk(clk), .rst_(rst_), .bus(bus8.slave));
  fifo_ctrl #(.DEPTH(5)) dut5 (.clk(clk), .rst_(rst_), .bus(bus5.slave));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: apply inputs after the falling edge, compare outputs,
  // then advance the reference for the coming rising edge.
  task automatic cycle(input bit p, input bit q, input bit r);
    logic [31:0] o_pok, o_qok, o_wr, o_cnt, o_full, o_emp, o_af, o_sel;
    logic [31:0] o_of, o_uf;
    int d, cnt;
    bit e_push, e_pop;
    string id;
    @(negedge clk);
    bus8.push = p; bus5.push = p;
    bus8.pop  = q; bus5.pop  = q;
    rst_ = r;
    #1;
    for (int k = 0; k < 2; k++) begin
      o_of = '0;
      o_uf = '0;
      if (k == 0) begin
        o_pok = 32'(bus8.push_ok); o_qok = 32'(bus8.pop_ok);
        o_wr  = 32'(bus8.wr_en);   o_cnt = 32'(bus8.count);
        o_full = 32'(bus8.full);   o_emp = 32'(bus8.empty);
        o_af  = 32'(bus8.almost_full); o_sel = 32'(bus8.rd_sel);
`ifdef FIFO_CTRL_ERR_FLAGS_EN
        o_of = 32'(bus8.overflow); o_uf = 32'(bus8.underflow);
`endif
        id = "d8";
      end else begin
        o_pok = 32'(bus5.push_ok); o_qok = 32'(bus5.pop_ok);
        o_wr  = 32'(bus5.wr_en);   o_cnt = 32'(bus5.count);
        o_full = 32'(bus5.full);   o_emp = 32'(bus5.empty);
        o_af  = 32'(bus5.almost_full); o_sel = 32'(bus5.rd_sel);
`ifdef FIFO_CTRL_ERR_FLAGS_EN
        o_of = 32'(bus5.overflow); o_uf = 32'(bus5.underflow);
`endif
        id = "d5";
      end
      d   = dep[k];
      cnt = tot_push[k] - tot_pop[k];
      e_pop  = !r && q && (cnt > 0);
      e_push = !r && p && ((cnt < d) || q);
      check_val({id, "_push_ok"}, o_pok, 32'(e_push));
      check_val({id, "_pop_ok"},  o_qok, 32'(e_pop));
      check_val({id, "_wr_en"},   o_wr,
                e_push ? (32'd1 << (tot_push[k] % d)) : 32'd0);
      check_val({id, "_count"},   o_cnt, 32'(cnt));
      check_val({id, "_full"},    o_full, 32'(cnt == d));
      check_val({id, "_empty"},   o_emp, 32'(cnt == 0));
      check_val({id, "_almost_full"}, o_af, 32'(cnt >= af_lvl[k]));
      check_val({id, "_rd_sel"},  o_sel, 32'(tot_pop[k] % d));
`ifdef FIFO_CTRL_ERR_FLAGS_EN
      check_val({id, "_overflow"},  o_of, 32'(of_flag[k]));
      check_val({id, "_underflow"}, o_uf, 32'(uf_flag[k]));
`endif
      $display("cyc %s push=%0b pop=%0b rst=%0b count=%0d rd_sel=%0d wr_en=%0h",
               id, p, q, r, o_cnt, o_sel, o_wr);
      if (r) begin
        tot_push[k] = 0;
        tot_pop[k]  = 0;
        of_flag[k]  = 1'b0;
        uf_flag[k]  = 1'b0;
      end else begin
        if (p && (cnt == d) && !q) of_flag[k] = 1'b1;
        if (q && (cnt == 0))       uf_flag[k] = 1'b1;
        tot_push[k] += int'(e_push);
        tot_pop[k]  += int'(e_pop);
      end
    end
  endtask

  initial begin
    int bias_push, bias_pop;
    rst_ = 1'b1;
    bus8.push = 1'b0; bus8.pop = 1'b0;
    bus5.push = 1'b0; bus5.pop = 1'b0;
    // Bring state out of X before any comparison.
    repeat (2) @(posedge clk);

    cycle(0, 0, 1);
    // Eight pushes: wr_en walks one bit per push, almost_full from count 7.
    for (int i = 0; i < 8; i++) cycle(1, 0, 0);
    cycle(0, 0, 0);
    check_val("fill_count8", 32'(bus8.count), 32'd8);
    check_val("fill_full8",  32'(bus8.full),  32'd1);
    // Push+pop at full: both accepted, count holds.
    for (int i = 0; i < 3; i++) cycle(1, 1, 0);
    check_val("full_pp_count8", 32'(bus8.count), 32'd8);
    // Push at full alone is rejected.
    repeat (2) cycle(1, 0, 0);
    // Drain past empty.
    for (int i = 0; i < 10; i++) cycle(0, 1, 0);
    // Push+pop at empty: push only.
    cycle(1, 1, 0);
    cycle(0, 0, 0);
    check_val("empty_pp_count8", 32'(bus8.count), 32'd1);
    cycle(0, 1, 0);
    // Wrap with occupancy never above 1.
    for (int i = 0; i < 13; i++) begin
      cycle(1, 0, 0);
      cycle(0, 1, 0);
    end
    cycle(0, 0, 1);

    // Randomized traffic with drifting fill/drain bias and sparse resets.
    for (int blk = 0; blk < 10; blk++) begin
      bias_push = $urandom_range(20, 90);
      bias_pop  = $urandom_range(20, 90);
      for (int i = 0; i < 40; i++) begin
        cycle($urandom_range(0, 99) < bias_push,
              $urandom_range(0, 99) < bias_pop,
              $urandom_range(0, 63) == 0);
      end
    end

    // Reset at count 6 with push/pop active during reset.
    cycle(0, 0, 1);
    for (int i = 0; i < 6; i++) cycle(1, 0, 0);
    cycle(1, 1, 1);
    cycle(0, 0, 0);
    check_val("rst6_count8",  32'(bus8.count),  32'd0);
    check_val("rst6_empty8",  32'(bus8.empty),  32'd1);
    check_val("rst6_rd_sel8", 32'(bus8.rd_sel), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_ctrl.md
# fifo_ctrl

Control block for a register-bank FIFO: tracks write/read pointers and occupancy, and drives the per-entry write enables and read-select of a bank of `DEPTH` enabled data registers, each `DATA_WIDTH` wide. The registers and output mux are outside this block; it owns only sequencing and status. It sits between the producer/consumer push/pop interface and the storage bank.

## Interface
- `DEPTH`, 8, number of storage entries; legal range 2..256, need not be a power of two.
- `AF_LEVEL`, DEPTH-1, occupancy at or above which `almost_full` asserts; legal range 1..DEPTH.
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst_` input 1: synchronous, active-high reset.
- `push` input 1: write request from the producer.
- `pop` input 1: read request from the consumer.
- `wr_en` output DEPTH: one-hot enable to the storage registers; at most one bit set.
- `rd_sel` output $clog2(DEPTH): index of the entry currently presented at the FIFO output.
- `push_ok` output 1: push accepted this cycle.
- `pop_ok` output 1: pop accepted this cycle.
- `full` output 1: count == DEPTH.
- `empty` output 1: count == 0.
- `almost_full` output 1: count >= AF_LEVEL.
- `count` output $clog2(DEPTH+1): current occupancy.
- `overflow` output 1: sticky error flag, present only with `FIFO_CTRL_ERR_FLAGS_EN`.
- `underflow` output 1: sticky error flag, present only with `FIFO_CTRL_ERR_FLAGS_EN`.

## Operation
- State: `wr_ptr`, `rd_ptr` (0..DEPTH-1), `count` (0..DEPTH).
- Accept rules:
  - `pop_ok = pop & ~empty`.
  - `push_ok = push & (~full | pop)`. When the FIFO is full, a simultaneous push and pop are both accepted.
  - When the FIFO is empty, a simultaneous push and pop accepts the push only.
- `wr_en[wr_ptr] = push_ok`; all other bits are 0.
- `rd_sel = rd_ptr`. The consumer samples the selected entry in the same cycle it asserts `pop`.
- Pointer updates:
  - On `push_ok`, `wr_ptr` increments and wraps from DEPTH-1 to 0.
  - On `pop_ok`, `rd_ptr` increments with the same wrap.
- Count updates:
  - `push_ok` only: +1.
  - `pop_ok` only: -1.
  - Both: unchanged.
  - Neither: unchanged.
- Invariant: `wr_ptr == (rd_ptr + count) mod DEPTH`.
- Storage contents are not cleared by reset. Entries are invalid until written.

## Timing
- `wr_en`, `push_ok` and `pop_ok` are combinational from `push`/`pop` and registered state. The storage register captures data on the same edge that advances `wr_ptr`.
- `full`, `empty`, `almost_full`, `count` and `rd_sel` are registered, or derived combinationally from registered state only. They reflect an accepted operation in the cycle after it.
- Write-to-read latency: data pushed at edge N is visible via `rd_sel` and `empty` = 0 from cycle N+1.
- Reset (`rst_` = 1 at an edge) has priority over push/pop, including mid-operation and at full. Values after reset:
  - `wr_ptr` = 0, `rd_ptr` = 0, `count` = 0.
  - `empty` = 1, `full` = 0, `almost_full` = 0.
  - `rd_sel` = 0, `overflow` = 0, `underflow` = 0.
- While `rst_` = 1, `wr_en` = 0, `push_ok` = 0 and `pop_ok` = 0.

## Configuration
- `FIFO_CTRL_ERR_FLAGS_EN` defined:
  - `overflow` sets on a cycle with `push & full & ~pop`.
  - `underflow` sets on a cycle with `pop & empty`.
  - Both flags hold until reset.
- `FIFO_CTRL_ERR_FLAGS_EN` undefined: `overflow` and `underflow` ports and their logic are absent. Rejected requests are silently dropped in both cases.

## Structure
- `fifo_pkg` holds:
  - the pointer and count width functions/localparams, derived from DEPTH;
  - the `ptr_t` typedef;
  - the default `DEPTH` constant shared with the storage bank and the testbench.
- Sub-module `wrap_ctr`: a pointer counter with increment enable and wrap at a parameterized MAX. It is instantiated twice, once for `wr_ptr` and once for `rd_ptr`.

## Test plan
- Reset, then 8 pushes with DEPTH=8 -> `wr_en` walks 0x01..0x80; `full` = 1 and `count` = 8 after the eighth; `almost_full` = 1 from count 7.
- Full FIFO, push+pop in the same cycle -> both accepted, `count` stays 8, `wr_en` = bit `rd_ptr`, `rd_ptr` advances by 1.
- Empty FIFO, push+pop in the same cycle -> `push_ok` = 1, `pop_ok` = 0, `count` = 1.
- Wrap: 13 push/pop pairs with DEPTH=5 -> pointers go 4 -> 0; `count` never exceeds 1; `rd_sel` tracks the oldest entry.
- Push at full / pop at empty, with the macro defined -> requests rejected, `overflow` / `underflow` = 1 and held until `rst_`.
- Assert `rst_` at count 6 -> next cycle `count` = 0, `empty` = 1, pointers = 0, `wr_en` = 0 during reset.
